// File: rtl/step_pkg.sv
// Shared definitions for the microstep sequencer: duty word field layout,
// quarter-wave table length, phase width and sequencer state encoding.
package step_pkg;

    localparam int PHASE_W    = 7;
    localparam int LUT_LEN    = 33;

    localparam int SIN_POS    = 15;
    localparam int SIN_MAG_HI = 14;
    localparam int SIN_MAG_LO = 8;
    localparam int COS_POS    = 7;
    localparam int COS_MAG_HI = 6;
    localparam int COS_MAG_LO = 0;

    // Word for phase 0: sin = +0, cos = +127.
    localparam logic [15:0] PHASE0_WORD = 16'h80FF;

    // A quarter turn of the 128-step electrical cycle; cos leads sin by this.
    localparam logic [PHASE_W-1:0] QUARTER_TURN = 7'd32;

    typedef enum logic {
        SEQ_INIT = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/step_sine_lut.sv
// Converts a 7-bit microstep phase into the packed sin/cos duty word.
// Only a quarter wave is stored; the other quadrants mirror the index
// and carry the sign in the pos bits.
module step_sine_lut
    import step_pkg::*;
(
    input  logic [PHASE_W-1:0] phase_i,
    output logic [15:0]        word_o
);

    localparam int IDX_W = $clog2(LUT_LEN);

    // round(127 * sin(k * pi / 64)) for k = 0..32
    function automatic logic [6:0] romMag(input logic [IDX_W-1:0] k);
        case (k)
            6'd0:  romMag = 7'd0;
            6'd1:  romMag = 7'd6;
            6'd2:  romMag = 7'd12;
            6'd3:  romMag = 7'd19;
            6'd4:  romMag = 7'd25;
            6'd5:  romMag = 7'd31;
            6'd6:  romMag = 7'd37;
            6'd7:  romMag = 7'd43;
            6'd8:  romMag = 7'd49;
            6'd9:  romMag = 7'd54;
            6'd10: romMag = 7'd60;
            6'd11: romMag = 7'd65;
            6'd12: romMag = 7'd71;
            6'd13: romMag = 7'd76;
            6'd14: romMag = 7'd81;
            6'd15: romMag = 7'd85;
            6'd16: romMag = 7'd90;
            6'd17: romMag = 7'd94;
            6'd18: romMag = 7'd98;
            6'd19: romMag = 7'd102;
            6'd20: romMag = 7'd106;
            6'd21: romMag = 7'd109;
            6'd22: romMag = 7'd112;
            6'd23: romMag = 7'd115;
            6'd24: romMag = 7'd117;
            6'd25: romMag = 7'd120;
            6'd26: romMag = 7'd122;
            6'd27: romMag = 7'd123;
            6'd28: romMag = 7'd125;
            6'd29: romMag = 7'd126;
            6'd30: romMag = 7'd126;
            6'd31: romMag = 7'd127;
            6'd32: romMag = 7'd127;
            default: romMag = 7'd0;
        endcase
    endfunction

    // Odd quadrants read the table backwards; the first half-cycle is positive.
    function automatic logic [7:0] halfWord(input logic [PHASE_W-1:0] p);
        logic [1:0]       quad;
        logic [IDX_W-1:0] fwd;
        logic [IDX_W-1:0] k;
        quad = p[6:5];
        fwd  = {1'b0, p[4:0]};
        k    = quad[0] ? (6'd32 - fwd) : fwd;
        halfWord = {(quad < 2'd2), romMag(k)};
    endfunction

    logic [PHASE_W-1:0] cosPhase;
    assign cosPhase = phase_i + QUARTER_TURN;

    // Pack the sin and cos halves into their word fields.
    always_comb begin
        word_o = '0;
        {word_o[SIN_POS], word_o[SIN_MAG_HI:SIN_MAG_LO]} = halfWord(phase_i);
        {word_o[COS_POS], word_o[COS_MAG_HI:COS_MAG_LO]} = halfWord(cosPhase);
    end

endmodule

// File: rtl/step_microstep_sequencer.sv
// Time-multiplexed microstep engine feeding the stepper PWM block. A scan
// pointer visits one channel per clock; each visit either counts down the
// step timer or advances the channel phase and emits one register write.
module step_microstep_sequencer
    import step_pkg::*;
#(
    parameter int          CHANNELS   = 32,
    parameter logic [15:0] BASE_INDEX = 16'h0000,
    localparam int         CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CW-1:0]       cmd_chan,
    input  logic                cmd_dir,
    input  logic [15:0]         cmd_steps,
    input  logic [15:0]         cmd_period,
    input  logic                stop_all,
    output logic [CHANNELS-1:0] busy,
    output logic                we,
    output logic [15:0]         regIndex,
    output logic [15:0]         regData
);

    seq_state_e         state_q;
    logic [CW-1:0]      scan_q;
    logic [CW-1:0]      scan_d;
    logic               we_q;
    logic [15:0]        regIndex_q;
    logic [15:0]        regData_q;

    logic [PHASE_W-1:0] phase_q  [CHANNELS];
    logic [15:0]        steps_q  [CHANNELS];
    logic [15:0]        timer_q  [CHANNELS];
    logic [15:0]        period_q [CHANNELS];
    logic [CHANNELS-1:0] dir_q;

    logic               lastScan;
    logic               accept;
    logic               visitActive;
    logic               visitStep;
    logic [PHASE_W-1:0] stepPhase;
    logic [15:0]        stepWord;

    assign we       = we_q;
    assign regIndex = regIndex_q;
    assign regData  = regData_q;

    // A channel is busy exactly while it still has steps to execute.
    always_comb begin
        busy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            busy[c] = (steps_q[c] != 16'd0);
        end
    end

    assign cmd_ready = (state_q == SEQ_RUN) && !busy[cmd_chan];
    assign accept    = cmd_valid && cmd_ready && !stop_all;
    assign lastScan  = (scan_q == CW'(CHANNELS - 1));
    assign scan_d    = lastScan ? '0 : scan_q + CW'(1);

    // Decide what the current visit does; a same-cycle command to the visited channel wins.
    always_comb begin
        visitActive = (state_q == SEQ_RUN) && !stop_all
                      && !(accept && (cmd_chan == scan_q))
                      && (steps_q[scan_q] != 16'd0);
        visitStep   = visitActive && (timer_q[scan_q] == 16'd0);
        stepPhase   = dir_q[scan_q] ? (phase_q[scan_q] + 7'd1) : (phase_q[scan_q] - 7'd1);
    end

    step_sine_lut u_lut (
        .phase_i (stepPhase),
        .word_o  (stepWord)
    );

    // Sequencer FSM: initial phase-0 sweep, then the free-running scan, with registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_INIT;
            scan_q     <= '0;
            we_q       <= 1'b0;
            regIndex_q <= '0;
            regData_q  <= '0;
        end else begin
            we_q   <= 1'b0;
            scan_q <= scan_d;
            case (state_q)
                SEQ_INIT: begin
                    we_q       <= 1'b1;
                    regIndex_q <= BASE_INDEX + 16'(scan_q);
                    regData_q  <= PHASE0_WORD;
                    if (lastScan) begin
                        state_q <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (visitStep) begin
                        we_q       <= 1'b1;
                        regIndex_q <= BASE_INDEX + 16'(scan_q);
                        regData_q  <= stepWord;
                    end
                end
                default: state_q <= SEQ_INIT;
            endcase
        end
    end

    // Per-channel move state: command loads, timer countdown, phase advance, global abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c]  <= '0;
                steps_q[c]  <= '0;
                timer_q[c]  <= '0;
                period_q[c] <= '0;
            end
            dir_q <= '0;
        end else if (stop_all) begin
            for (int c = 0; c < CHANNELS; c++) begin
                steps_q[c] <= '0;
            end
        end else begin
            if (accept) begin
                steps_q[cmd_chan]  <= cmd_steps;
                timer_q[cmd_chan]  <= cmd_period;
                period_q[cmd_chan] <= cmd_period;
                dir_q[cmd_chan]    <= cmd_dir;
            end
            if (visitActive) begin
                if (timer_q[scan_q] != 16'd0) begin
                    timer_q[scan_q] <= timer_q[scan_q] - 16'd1;
                end else begin
                    phase_q[scan_q] <= stepPhase;
                    steps_q[scan_q] <= steps_q[scan_q] - 16'd1;
                    timer_q[scan_q] <= period_q[scan_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_step_microstep_sequencer.sv
// Bench for the microstep sequencer. The reference model predicts, for each
// accepted command, the exact cycle and content of every write from the scan
// schedule and a floating-point sine, and tracks per-channel phase and busy.
module tb_step_microstep_sequencer;

    localparam int  CH = 32;
    localparam real PI = 3.14159265358979;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_chan = '0;
    logic          cmd_dir = 1'b0;
    logic [15:0]   cmd_steps = '0;
    logic [15:0]   cmd_period = '0;
    logic          stop_all = 1'b0;
    logic [CH-1:0] busy;
    logic          we;
    logic [15:0]   regIndex;
    logic [15:0]   regData;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int runCyc  = 0;

    int expIdx[int];
    int expPh[int];
    bit expDir[int];
    int modelPhase[CH];
    int busyEnd[CH];

    step_microstep_sequencer #(
        .CHANNELS   (CH),
        .BASE_INDEX (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .stop_all   (stop_all),
        .busy       (busy),
        .we         (we),
        .regIndex   (regIndex),
        .regData    (regData)
    );

    always #5 clk = ~clk;

    // Cycle label: value seen at a negedge names the current clock cycle.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int halfModel(input int p);
        int  q;
        int  i;
        int  k;
        real x;
        q = p / 32;
        i = p % 32;
        k = (q % 2 == 1) ? 32 - i : i;
        x = 127.0 * $sin(real'(k) * PI / 64.0);
        return ((q < 2) ? 128 : 0) + $rtoi(x + 0.5);
    endfunction

    function automatic logic [15:0] modelWord(input int p);
        return 16'(halfModel(p) * 256 + halfModel((p + 32) % 128));
    endfunction

    function automatic bit modelBusy(input int c);
        return cyc < busyEnd[c];
    endfunction

    function automatic int lastEnd();
        int m;
        m = cyc;
        for (int c = 0; c < CH; c++) if (busyEnd[c] > m) m = busyEnd[c];
        return m;
    endfunction

    // Visits of channel c fall on cycles where (cycle - runCyc) mod CH == c; the
    // visit in the accept cycle itself is lost to the command.
    function automatic void scheduleCmd(input int a, input int c, input bit d, input int steps, input int period);
        int off;
        int v1;
        int ph;
        int w;
        off = ((c - (a - runCyc)) % CH + CH) % CH;
        if (off == 0) off = CH;
        v1 = a + off;
        ph = modelPhase[c];
        for (int k = 1; k <= steps; k++) begin
            ph = d ? (ph + 1) % 128 : (ph + 127) % 128;
            w  = v1 + CH * (k * (period + 1) - 1) + 1;
            expIdx[w] = c;
            expPh[w]  = ph;
            expDir[w] = d;
            busyEnd[c] = w;
        end
        modelPhase[c] = ph;
    endfunction

    // Drop every write that would appear after the abort cycle and roll phases back.
    function automatic void applyStop(input int s);
        int keys[$];
        bit seen[CH];
        foreach (expIdx[k]) if (k > s) keys.push_back(k);
        foreach (keys[j]) begin
            int c;
            c = expIdx[keys[j]];
            if (!seen[c]) begin
                seen[c] = 1'b1;
                modelPhase[c] = expDir[keys[j]] ? (expPh[keys[j]] + 127) % 128 : (expPh[keys[j]] + 1) % 128;
            end
            expIdx.delete(keys[j]);
            expPh.delete(keys[j]);
            expDir.delete(keys[j]);
        end
        for (int c = 0; c < CH; c++) if (busyEnd[c] > s) busyEnd[c] = s + 1;
    endfunction

    task automatic doReset(input int n);
        rst = 1'b1;
        cmd_valid = 1'b0;
        stop_all = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        runCyc = cyc + 32;
        expIdx.delete();
        expPh.delete();
        expDir.delete();
        for (int c = 0; c < CH; c++) begin
            modelPhase[c] = 0;
            busyEnd[c] = 0;
        end
    endtask

    // Called at a negedge; holds the command for one edge and returns the observed and predicted ready.
    task automatic issueCmd(input int c, input bit d, input int steps, input int period, output bit gotReady, output bit wantReady);
        wantReady = (cyc >= runCyc) && !modelBusy(c);
        cmd_chan   = 5'(c);
        cmd_dir    = d;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(period);
        cmd_valid  = 1'b1;
        #1 gotReady = cmd_ready;
        if (wantReady && !stop_all) scheduleCmd(cyc, c, d, steps, period);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if (we !== 1'b0 || regIndex !== 16'h0 || regData !== 16'h0 || busy !== '0 || cmd_ready !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset_values got we=%b idx=%h data=%h busy=%h ready=%b want all zero", we, regIndex, regData, busy, cmd_ready);
        end
        doReset(1);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            nChecks++;
            if (we !== 1'b1 || regIndex !== 16'(j) || regData !== modelWord(0)) begin
                nFail++;
                $display("[TB] FAIL init_write j=%0d got we=%b idx=%h data=%h want idx=%h data=%h", j, we, regIndex, regData, 16'(j), modelWord(0));
            end
            nChecks++;
            if (cmd_ready !== (j == 31)) begin
                nFail++;
                $display("[TB] FAIL init_ready j=%0d got %b want %b", j, cmd_ready, (j == 31));
            end
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            nChecks++;
            if (we !== 1'b0 || cmd_ready !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL idle_run got we=%b ready=%b want we=0 ready=1", we, cmd_ready);
            end
        end
    endtask

    task automatic test_step_up();
        bit got;
        bit want;
        int len;
        issueCmd(3, 1'b1, 2, 0, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL stepUp_ready got %b want %b", got, want);
        end
        len = busyEnd[3] - cyc + 2;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL stepUp_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL stepUp_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
            if (cyc == busyEnd[3] - 1 || cyc == busyEnd[3]) begin
                nChecks++;
                if (busy[3] !== (cyc == busyEnd[3] - 1)) begin
                    nFail++;
                    $display("[TB] FAIL stepUp_busy cyc=%0d got %b want %b", cyc, busy[3], (cyc == busyEnd[3] - 1));
                end
            end
        end
    endtask

    task automatic test_step_down();
        bit got;
        bit want;
        int len;
        issueCmd(5, 1'b0, 1, 0, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL stepDown_ready got %b want %b", got, want);
        end
        len = busyEnd[5] - cyc + 2;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL stepDown_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL stepDown_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
        end
    endtask

    task automatic test_period();
        bit got;
        bit want;
        int len;
        issueCmd(7, 1'b1, 3, 2, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL period_ready got %b want %b", got, want);
        end
        len = busyEnd[7] - cyc + 2;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL period_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL period_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
            if (n == 10 || n == 150) begin
                issueCmd(7, 1'b0, 1, 0, got, want);
                nChecks++;
                if (got !== want) begin
                    nFail++;
                    $display("[TB] FAIL period_busyReady n=%0d got %b want %b", n, got, want);
                end
            end
        end
    endtask

    task automatic test_stop_all();
        bit got;
        bit want;
        int len;
        issueCmd(3, 1'b1, 6, 0, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL stop_ready got %b want %b", got, want);
        end
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL stop_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL stop_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
            if (n == 71) begin
                nChecks++;
                if (busy !== '0) begin
                    nFail++;
                    $display("[TB] FAIL stop_busy got %h want 0", busy);
                end
            end
            if (n == 70) begin
                stop_all = 1'b1;
                applyStop(cyc);
                issueCmd(9, 1'b1, 3, 0, got, want);
                stop_all = 1'b0;
                nChecks++;
                if (got !== want) begin
                    nFail++;
                    $display("[TB] FAIL stop_sameCycleReady got %b want %b", got, want);
                end
            end
        end
        issueCmd(3, 1'b1, 1, 0, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL resume_ready got %b want %b", got, want);
        end
        len = busyEnd[3] - cyc + 2;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL resume_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL resume_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        bit got;
        bit want;
        int len;
        issueCmd(10, 1'b1, 5, 0, got, want);
        for (int n = 0; n < 40; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if (we !== 1'b0 || busy !== '0 || cmd_ready !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL midReset_values got we=%b busy=%h ready=%b want 0", we, busy, cmd_ready);
        end
        doReset(1);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            nChecks++;
            if (we !== 1'b1 || regIndex !== 16'(j) || regData !== modelWord(0)) begin
                nFail++;
                $display("[TB] FAIL midReset_init j=%0d got we=%b idx=%h data=%h want idx=%h data=%h", j, we, regIndex, regData, 16'(j), modelWord(0));
            end
        end
        issueCmd(10, 1'b1, 1, 0, got, want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL midReset_ready got %b want %b", got, want);
        end
        len = 80;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL midReset_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL midReset_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
            if (n == 0) issueCmd(3, 1'b0, 1, 0, got, want);
        end
    endtask

    task automatic test_random();
        bit got;
        bit want;
        int gap;
        int len;
        for (int it = 0; it < 30; it++) begin
            gap = $urandom_range(1, 12);
            for (int n = 0; n < gap; n++) begin
                @(negedge clk);
                nChecks++;
                if (expIdx.exists(cyc)) begin
                    if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                        nFail++;
                        $display("[TB] FAIL random_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                    end
                end else if (we !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL random_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
                end
            end
            issueCmd($urandom_range(0, CH - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 2), got, want);
            nChecks++;
            if (got !== want) begin
                nFail++;
                $display("[TB] FAIL random_ready it=%0d got %b want %b", it, got, want);
            end
        end
        len = lastEnd() - cyc + 2;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            nChecks++;
            if (expIdx.exists(cyc)) begin
                if (we !== 1'b1 || regIndex !== 16'(expIdx[cyc]) || regData !== modelWord(expPh[cyc])) begin
                    nFail++;
                    $display("[TB] FAIL drain_write cyc=%0d got we=%b idx=%h data=%h want idx=%h data=%h", cyc, we, regIndex, regData, 16'(expIdx[cyc]), modelWord(expPh[cyc]));
                end
            end else if (we !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL drain_idle cyc=%0d got we=%b idx=%h want we=0", cyc, we, regIndex);
            end
        end
        nChecks++;
        if (busy !== '0) begin
            nFail++;
            $display("[TB] FAIL drain_busy got %h want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_step_down();
        test_period();
        test_stop_all();
        test_reset_mid_move();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
